// File: rtl/vehicle_can_pkg.sv
// Shared CAN frame definitions for the vehicle data receiver and generator:
// default IDs, decoded field widths, and the receiver FSM states.
package vehicle_can_pkg;

  localparam logic [10:0] DEFAULT_ID_ENGINE_REV = 11'h3D9;
  localparam logic [10:0] DEFAULT_ID_CAR_SPEED  = 11'h3E9;

  localparam int ENGINE_REV_W    = 14;
  localparam int VEHICLE_SPEED_W = 9;
  localparam int BATTERY_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    PARSE = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [10:0] id;
    logic [63:0] data;
    logic [7:0]  keep;
  } can_frame_t;

endpackage

// File: rtl/staleness_timer.sv
// Per-ID freshness watchdog: counts cycles since the last valid frame and
// flags the ID stale once TIMEOUT_CYCLE cycles pass without one.
module staleness_timer #(
  parameter int unsigned TIMEOUT_CYCLE = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic stale
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);

  logic [CNT_W-1:0] count_reg;
  logic             at_limit;
  logic             reaching;

  assign at_limit = (count_reg == CNT_W'(TIMEOUT_CYCLE));
  assign reaching = (count_reg == CNT_W'(TIMEOUT_CYCLE - 1));

  // A clear wins over the reach event landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      stale     <= 1'b1;
    end else if (clear) begin
      count_reg <= '0;
      stale     <= 1'b0;
    end else if (!at_limit) begin
      count_reg <= count_reg + CNT_W'(1);
      if (reaching) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vehicle_data_receiver.sv
// Accepts CAN frames from a stream, decodes engine-rev and speed/battery
// frames into held outputs, counts malformed frames and tracks staleness.
module vehicle_data_receiver
  import vehicle_can_pkg::*;
#(
  parameter logic [10:0] ID_ENGINE_REV = DEFAULT_ID_ENGINE_REV,
  parameter logic [10:0] ID_CAR_SPEED  = DEFAULT_ID_CAR_SPEED,
  parameter int unsigned TIMEOUT_CYCLE = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                stm_recv_data_in_tdata,
  input  logic [10:0]                stm_recv_data_in_tid,
  input  logic [7:0]                 stm_recv_data_in_tkeep,
  input  logic                       stm_recv_data_in_tvalid,
  output logic                       stm_recv_data_in_tready,
  output logic [ENGINE_REV_W-1:0]    engine_rev,
  output logic [VEHICLE_SPEED_W-1:0] vehicle_speed,
  output logic [BATTERY_W-1:0]       battery_value,
  output logic                       rev_update,
  output logic                       speed_update,
  output logic                       rev_stale,
  output logic                       speed_stale,
  output logic [7:0]                 frame_err_count
);

  rx_state_t  state_reg, state_next;
  can_frame_t frame_reg;

  logic is_parse;
  logic rev_hit, speed_hit;
  logic rev_ok, rev_bad, speed_ok, speed_bad;
  logic frame_unused;

  always_comb begin
    state_next              = state_reg;
    stm_recv_data_in_tready = 1'b0;
    case (state_reg)
      IDLE: begin
        stm_recv_data_in_tready = 1'b1;
        if (stm_recv_data_in_tvalid) begin
          state_next = PARSE;
        end
      end
      PARSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The frame register is only loaded on an IDLE handshake, so inputs seen
  // during PARSE never reach the decoder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg <= '0;
    end else if (state_reg == IDLE && stm_recv_data_in_tvalid) begin
      frame_reg <= '{id:   stm_recv_data_in_tid,
                     data: stm_recv_data_in_tdata,
                     keep: stm_recv_data_in_tkeep};
    end
  end

  assign is_parse  = (state_reg == PARSE);
  assign rev_hit   = is_parse && (frame_reg.id == ID_ENGINE_REV);
  assign speed_hit = is_parse && (frame_reg.id == ID_CAR_SPEED);
  assign rev_ok    = rev_hit   && (frame_reg.keep[1:0] == 2'b11);
  assign rev_bad   = rev_hit   && (frame_reg.keep[1:0] != 2'b11);
  assign speed_ok  = speed_hit && (frame_reg.keep[2:0] == 3'b111);
  assign speed_bad = speed_hit && (frame_reg.keep[2:0] != 3'b111);

  assign frame_unused = ^{frame_reg.data[63:24], frame_reg.data[7:6], frame_reg.keep[7:3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      engine_rev      <= '0;
      vehicle_speed   <= '0;
      battery_value   <= '0;
      rev_update      <= 1'b0;
      speed_update    <= 1'b0;
      frame_err_count <= '0;
    end else begin
      rev_update   <= rev_ok;
      speed_update <= speed_ok;
      if (rev_ok) begin
        engine_rev <= {frame_reg.data[5:0], frame_reg.data[15:8]};
      end
      if (speed_ok) begin
        vehicle_speed <= {frame_reg.data[0], frame_reg.data[15:8]};
        battery_value <= frame_reg.data[23:16];
      end
      if ((rev_bad || speed_bad) && frame_err_count != 8'hFF) begin
        frame_err_count <= frame_err_count + 8'd1;
      end
    end
  end

  // Index 0 watches the engine-rev ID, index 1 the speed ID.
  logic [1:0] timer_clear;
  logic [1:0] timer_stale;

  assign timer_clear = {speed_ok, rev_ok};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_timer
      staleness_timer #(
        .TIMEOUT_CYCLE(TIMEOUT_CYCLE)
      ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear[gi]),
        .stale(timer_stale[gi])
      );
    end
  endgenerate

  assign rev_stale   = timer_stale[0];
  assign speed_stale = timer_stale[1];

endmodule

// File: tb/tb_vehicle_data_receiver.sv
// Scoreboard bench for vehicle_data_receiver: the driver predicts each frame's
// outcome into a queue, the monitor checks it when parsing completes.
module tb_vehicle_data_receiver;
  import vehicle_can_pkg::*;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic [10:0] tid = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [13:0] engine_rev;
  logic [8:0]  vehicle_speed;
  logic [7:0]  battery_value;
  logic        rev_update, speed_update, rev_stale, speed_stale;
  logic [7:0]  frame_err_count;

  vehicle_data_receiver #(
    .ID_ENGINE_REV(11'h3D9),
    .ID_CAR_SPEED (11'h3E9),
    .TIMEOUT_CYCLE(TO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stm_recv_data_in_tdata (tdata),
    .stm_recv_data_in_tid   (tid),
    .stm_recv_data_in_tkeep (tkeep),
    .stm_recv_data_in_tvalid(tvalid),
    .stm_recv_data_in_tready(tready),
    .engine_rev             (engine_rev),
    .vehicle_speed          (vehicle_speed),
    .battery_value          (battery_value),
    .rev_update             (rev_update),
    .speed_update           (speed_update),
    .rev_stale              (rev_stale),
    .speed_stale            (speed_stale),
    .frame_err_count        (frame_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rev_upd;
    bit spd_upd;
    int rev;
    int spd;
    int bat;
    int err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_rev = 0, m_spd = 0, m_bat = 0, m_err = 0;
  int reset_epoch = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one accepted frame from the frame rules alone.
  task automatic predict(input logic [10:0] id, input logic [7:0] keep, input logic [63:0] data);
    exp_t e;
    e.rev_upd = 1'b0;
    e.spd_upd = 1'b0;
    if (id == 11'h3D9) begin
      if (keep[0] && keep[1]) begin
        m_rev = int'(data[5:0]) * 256 + int'(data[15:8]);
        e.rev_upd = 1'b1;
      end else if (m_err < 255) m_err++;
    end else if (id == 11'h3E9) begin
      if (keep[0] && keep[1] && keep[2]) begin
        m_spd = int'(data[0]) * 256 + int'(data[15:8]);
        m_bat = int'(data[23:16]);
        e.spd_upd = 1'b1;
      end else if (m_err < 255) m_err++;
    end
    e.rev = m_rev;
    e.spd = m_spd;
    e.bat = m_bat;
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic send(input logic [10:0] id, input logic [7:0] keep, input logic [63:0] data);
    int waitc = 0;
    @(negedge clk);
    tvalid = 1'b1;
    tid    = id;
    tkeep  = keep;
    tdata  = data;
    while (!tready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 10) begin
        chk("accept_timeout", 0, 1);
        return;
      end
    end
    $display("frame id=%h keep=%h data=%h", id, keep, data);
    predict(id, keep, data);
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    tdata  = {$urandom, $urandom};
  endtask

  // Monitor: completion of PARSE shows as tready returning high.
  initial begin : monitor
    bit   prev_rdy = 1'b1;
    int   low_run = 0;
    int   cyc = 0;
    int   last_rev = -1, last_spd = -1;
    int   seen_epoch = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (seen_epoch != reset_epoch) begin
        seen_epoch = reset_epoch;
        last_rev = -1;
        last_spd = -1;
        prev_rdy = 1'b1;
        low_run  = 0;
      end
      if (rst) begin
        prev_rdy = 1'b1;
        low_run  = 0;
        last_rev = -1;
        last_spd = -1;
        continue;
      end
      if (tready && !prev_rdy) begin
        chk("parse_len", low_run, 1);
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rev_update", int'(rev_update), int'(e.rev_upd));
          chk("speed_update", int'(speed_update), int'(e.spd_upd));
          chk("engine_rev", int'(engine_rev), e.rev);
          chk("vehicle_speed", int'(vehicle_speed), e.spd);
          chk("battery_value", int'(battery_value), e.bat);
          chk("frame_err_count", int'(frame_err_count), e.err);
          if (e.rev_upd) last_rev = cyc;
          if (e.spd_upd) last_spd = cyc;
        end
      end else begin
        chk("rev_update_quiet", int'(rev_update), 0);
        chk("speed_update_quiet", int'(speed_update), 0);
      end
      low_run  = tready ? 0 : low_run + 1;
      prev_rdy = tready;
      chk("rev_stale", int'(rev_stale), int'(last_rev < 0 || cyc - last_rev >= TO));
      chk("speed_stale", int'(speed_stale), int'(last_spd < 0 || cyc - last_spd >= TO));
    end
  end

  initial begin : driver
    int waitc;
    logic [10:0] rid;
    logic [7:0]  rkeep;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", int'(tready), 1);
    chk("rst_engine_rev", int'(engine_rev), 0);
    chk("rst_vehicle_speed", int'(vehicle_speed), 0);
    chk("rst_battery", int'(battery_value), 0);
    chk("rst_err", int'(frame_err_count), 0);
    chk("rst_rev_stale", int'(rev_stale), 1);
    chk("rst_speed_stale", int'(speed_stale), 1);
    @(posedge clk);
    #2 rst = 1'b0;

    send(11'h3D9, 8'h03, 64'hFFFF_FFFF_FFFF_12C5); idle();
    send(11'h3E9, 8'h07, 64'h0000_0000_009A_F401); idle();
    send(11'h3E9, 8'h03, 64'h0000_0000_0055_AA01); idle();

    send(11'h3D9, 8'hFF, {$urandom, $urandom});
    send(11'h3E9, 8'h07, {$urandom, $urandom});
    send(11'h123, 8'hFF, {$urandom, $urandom});
    send(11'h3D9, 8'h03, {$urandom, $urandom});
    idle();

    // Second speed frame written exactly TO edges after the first.
    send(11'h3E9, 8'h07, {$urandom, $urandom}); idle();
    repeat (98) @(negedge clk);
    send(11'h3E9, 8'h07, {$urandom, $urandom}); idle();
    repeat (TO + 20) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: rid = 11'h3D9;
        1: rid = 11'h3E9;
        2: rid = 11'h123;
        default: rid = 11'($urandom);
      endcase
      rkeep = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      send(rid, rkeep, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    repeat (4) @(negedge clk);

    // Reset pulse inside PARSE discards the held frame.
    send(11'h3D9, 8'h03, {$urandom, 32'h0000_3F3F});
    @(posedge clk);
    #2;
    rst = 1'b1;
    tvalid = 1'b0;
    sb.delete();
    m_rev = 0; m_spd = 0; m_bat = 0; m_err = 0;
    reset_epoch++;
    #1;
    chk("mid_rst_engine_rev", int'(engine_rev), 0);
    chk("mid_rst_speed", int'(vehicle_speed), 0);
    chk("mid_rst_battery", int'(battery_value), 0);
    chk("mid_rst_err", int'(frame_err_count), 0);
    chk("mid_rst_tready", int'(tready), 1);
    chk("mid_rst_rev_stale", int'(rev_stale), 1);
    chk("mid_rst_speed_stale", int'(speed_stale), 1);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      send(11'h3E9, 8'h03, {$urandom, $urandom});
    end
    idle();

    waitc = 0;
    while (sb.size() > 0 && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("err_saturated", int'(frame_err_count), 255);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
